// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: burst-mode SPI serial-clock generator.
// Each burst runs a lead half-period, 2*nbits SCLK edges with per-edge
// sample/shift strobes, and a tail half-period. All outputs are registered
// and everything runs on clk_in; SCLK is only ever a data output.
module spi_sclk_gen #(
  parameter int DIV_WIDTH = 8,
  parameter int MAX_BITS  = 32
) (
  input  logic                          clk_in,
  input  logic                          rst_n,
  input  logic [DIV_WIDTH-1:0]          div_i,
  input  logic                          cpol_i,
  input  logic                          cpha_i,
  input  logic [$clog2(MAX_BITS+1)-1:0] nbits_i,
  input  logic                          start_i,
  input  logic                          abort_i,
  output logic                          sclk_o,
  output logic                          busy_o,
  output logic                          sample_stb_o,
  output logic                          shift_stb_o,
  output logic                          done_o
);

  localparam int NB_W = $clog2(MAX_BITS + 1);
  localparam int EC_W = $clog2(2 * MAX_BITS + 1);
  localparam logic [NB_W-1:0] MAX_N = NB_W'(MAX_BITS);

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    RUN,
    TAIL
  } state_t;

  state_t               r_state;
  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] r_halfCnt;
  logic                 r_cpol;
  logic                 r_cpha;
  logic [NB_W-1:0]      r_nbits;
  logic [EC_W-1:0]      r_edgeCnt;
  logic                 r_sclk;
  logic                 r_busy;
  logic                 r_sample;
  logic                 r_shift;
  logic                 r_done;

  logic                 w_startOk;
  logic                 w_halfDone;
  logic [EC_W-1:0]      w_lastEdge;
  logic [EC_W-1:0]      w_nextEdge;
  logic                 w_nextLead;
  logic                 w_sampleNext;
  logic                 w_shiftNext;

  // A start only counts with a legal bit count and no simultaneous abort.
  assign w_startOk  = start_i && !abort_i && (nbits_i != '0) && (nbits_i <= MAX_N);

  // The half-period counter stops at r_div, so div = all-ones cannot wrap it.
  assign w_halfDone = (r_halfCnt == r_div);

  // Edges are numbered 1..2*nbits; odd edges are leading, even are trailing.
  assign w_lastEdge = EC_W'({r_nbits, 1'b0});
  assign w_nextEdge = r_edgeCnt + EC_W'(1);
  assign w_nextLead = w_nextEdge[0];

  // CPHA=0 samples on leading edges and shifts on trailing ones (but not after
  // the final bit); CPHA=1 shifts on leading edges and samples on trailing.
  assign w_sampleNext = r_cpha ? !w_nextLead : w_nextLead;
  assign w_shiftNext  = r_cpha ? w_nextLead
                               : (!w_nextLead && (w_nextEdge != w_lastEdge));

  // Burst sequencer: owns state, counters and every registered output.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_div     <= '0;
      r_halfCnt <= '0;
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_nbits   <= '0;
      r_edgeCnt <= '0;
      r_sclk    <= 1'b0;
      r_busy    <= 1'b0;
      r_sample  <= 1'b0;
      r_shift   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_sample <= 1'b0;
      r_shift  <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        IDLE: begin
          r_sclk <= cpol_i;
          if (w_startOk) begin
            r_div     <= div_i;
            r_cpol    <= cpol_i;
            r_cpha    <= cpha_i;
            r_nbits   <= nbits_i;
            r_halfCnt <= '0;
            r_edgeCnt <= '0;
            r_busy    <= 1'b1;
            r_state   <= LEAD;
          end
        end
        LEAD: begin
          if (abort_i) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_sclk    <= r_cpol;
            r_halfCnt <= '0;
            r_edgeCnt <= '0;
          end else if (!w_halfDone) begin
            r_halfCnt <= r_halfCnt + DIV_WIDTH'(1);
          end else begin
            r_halfCnt <= '0;
            r_state   <= RUN;
            r_sclk    <= ~r_sclk;
            r_edgeCnt <= w_nextEdge;
            r_sample  <= w_sampleNext;
            r_shift   <= w_shiftNext;
          end
        end
        RUN: begin
          if (abort_i) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_sclk    <= r_cpol;
            r_halfCnt <= '0;
            r_edgeCnt <= '0;
          end else if (!w_halfDone) begin
            r_halfCnt <= r_halfCnt + DIV_WIDTH'(1);
          end else if (r_edgeCnt == w_lastEdge) begin
            r_halfCnt <= '0;
            r_state   <= TAIL;
          end else begin
            r_halfCnt <= '0;
            r_sclk    <= ~r_sclk;
            r_edgeCnt <= w_nextEdge;
            r_sample  <= w_sampleNext;
            r_shift   <= w_shiftNext;
          end
        end
        TAIL: begin
          if (abort_i) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_sclk    <= r_cpol;
            r_halfCnt <= '0;
            r_edgeCnt <= '0;
          end else if (!w_halfDone) begin
            r_halfCnt <= r_halfCnt + DIV_WIDTH'(1);
          end else begin
            r_halfCnt <= '0;
            r_edgeCnt <= '0;
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_sclk    <= r_cpol;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sclk_o       = r_sclk;
  assign busy_o       = r_busy;
  assign sample_stb_o = r_sample;
  assign shift_stb_o  = r_shift;
  assign done_o       = r_done;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// tb_spi_sclk_gen: scoreboard bench for spi_sclk_gen.
// A cycle-level reference model predicts each burst from its start cycle with
// plain arithmetic and queues the cycles where outputs change or strobe; a
// separate monitor pops and compares whenever the DUT shows such a cycle.
module tb_spi_sclk_gen;

  localparam int DIV_WIDTH = 8;
  localparam int MAX_BITS  = 32;
  localparam int NB_W      = $clog2(MAX_BITS + 1);

  typedef struct {
    int         cyc;
    logic [4:0] v;
  } evt_t;

  logic                 clk_in  = 1'b0;
  logic                 rst_n   = 1'b1;
  logic [DIV_WIDTH-1:0] divI    = '0;
  logic                 cpolI   = 1'b0;
  logic                 cphaI   = 1'b0;
  logic [NB_W-1:0]      nbitsI  = '0;
  logic                 startI  = 1'b0;
  logic                 abortI  = 1'b0;
  logic                 sclkO;
  logic                 busyO;
  logic                 sampleO;
  logic                 shiftO;
  logic                 doneO;

  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  bit   inReset    = 1'b1;
  evt_t expQ[$];
  evt_t monEvt;
  logic [4:0] monAct;
  logic [4:0] monPrev = '0;

  bit         mActive = 1'b0;
  int         mP      = 0;
  int         mL      = 0;
  int         mH      = 1;
  int         mN      = 1;
  logic       mCpol   = 1'b0;
  logic       mCpha   = 1'b0;
  logic [4:0] mPrev   = '0;

  spi_sclk_gen #(
    .DIV_WIDTH(DIV_WIDTH),
    .MAX_BITS (MAX_BITS)
  ) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .div_i       (divI),
    .cpol_i      (cpolI),
    .cpha_i      (cphaI),
    .nbits_i     (nbitsI),
    .start_i     (startI),
    .abort_i     (abortI),
    .sclk_o      (sclkO),
    .busy_o      (busyO),
    .sample_stb_o(sampleO),
    .shift_stb_o (shiftO),
    .done_o      (doneO)
  );

  // Free-running system clock, period 10.
  always #5 clk_in = ~clk_in;

  // Cycle number of the outputs currently visible on the DUT.
  always @(posedge clk_in) cyc <= cyc + 1;

  // Expected {sclk, busy, sample, shift, done} at offset t into a busy burst:
  // half-period h=0 is the lead, h=1..2n each open with edge h, h=2n+1 is the tail.
  function automatic logic [4:0] expBurst(int t);
    int   h;
    int   ph;
    logic s;
    logic edgeHit;
    logic lead;
    logic smp;
    logic sh;
    h       = t / mH;
    ph      = t % mH;
    lead    = (h % 2) == 1;
    s       = (h >= 1 && h <= 2 * mN && lead) ? ~mCpol : mCpol;
    edgeHit = (ph == 0) && (h >= 1) && (h <= 2 * mN);
    smp     = edgeHit && (mCpha ? !lead : lead);
    sh      = edgeHit && (mCpha ? lead : (!lead && h != 2 * mN));
    return {s, 1'b1, smp, sh, 1'b0};
  endfunction

  // Reference model: predicts the outputs of the next cycle from the inputs
  // that the coming clock edge will sample, queueing only eventful cycles.
  task automatic modelStep();
    int         c;
    logic [4:0] e;
    c = cyc + 1;
    if (mActive) begin
      if (abortI) begin
        e       = {mCpol, 4'b0000};
        mActive = 1'b0;
      end else if (c - mP == mL) begin
        e       = {mCpol, 4'b0001};
        mActive = 1'b0;
      end else begin
        e = expBurst(c - mP);
      end
    end else if (startI && !abortI && int'(nbitsI) >= 1 && int'(nbitsI) <= MAX_BITS) begin
      mActive = 1'b1;
      mP      = c;
      mH      = int'(divI) + 1;
      mN      = int'(nbitsI);
      mCpol   = cpolI;
      mCpha   = cphaI;
      mL      = (2 * mN + 2) * mH;
      e       = expBurst(0);
    end else begin
      e = {cpolI, 4'b0000};
    end
    if (e[2:0] != 3'b000 || e[4] != mPrev[4] || e[3] != mPrev[3])
      expQ.push_back('{cyc: c, v: e});
    mPrev = e;
  endtask

  // Monitor: every cycle where the DUT strobes or changes sclk/busy is an
  // output event and must match the head of the expected queue.
  always @(negedge clk_in) begin
    monAct = {sclkO, busyO, sampleO, shiftO, doneO};
    if (!inReset) begin
      while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
        monEvt = expQ.pop_front();
        compared++;
        mismatched++;
        $display("[TB] FAIL missedEvent: cycle %0d got no output event, required outputs %b",
                 monEvt.cyc, monEvt.v);
      end
      if (monAct[2:0] !== 3'b000 || monAct[4] !== monPrev[4] || monAct[3] !== monPrev[3]) begin
        compared++;
        if (expQ.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL unexpectedEvent: cycle %0d got outputs %b, required no event",
                   cyc, monAct);
        end else begin
          monEvt = expQ.pop_front();
          if (monEvt.cyc != cyc || monEvt.v !== monAct) begin
            mismatched++;
            $display("[TB] FAIL eventCheck: got cycle %0d outputs %b, required cycle %0d outputs %b",
                     cyc, monAct, monEvt.cyc, monEvt.v);
          end
        end
      end
    end
    monPrev = monAct;
  end

  // Direct comparison used for reset behaviour and end-of-run bookkeeping.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // One clock: model the upcoming cycle, then step to just past the next negedge.
  task automatic tick();
    modelStep();
    @(negedge clk_in);
    #1;
  endtask

  // Drive one cycle of inputs; start and abort are single-cycle pulses.
  task automatic applyStimulus(input bit st, input bit ab, input int dv,
                               input bit cp, input bit ch, input int nb);
    startI = st;
    abortI = ab;
    divI   = DIV_WIDTH'(dv);
    cpolI  = cp;
    cphaI  = ch;
    nbitsI = NB_W'(nb);
    tick();
    startI = 1'b0;
    abortI = 1'b0;
  endtask

  // Idle or mid-burst cycles; scrambling the config shows it is ignored mid-burst.
  task automatic runCycles(input int n, input bit scramble);
    for (int i = 0; i < n; i++) begin
      if (scramble) begin
        divI   = DIV_WIDTH'($urandom);
        cpolI  = 1'($urandom_range(0, 1));
        cphaI  = 1'($urandom_range(0, 1));
        nbitsI = NB_W'($urandom_range(0, 63));
      end
      tick();
    end
  endtask

  // Run until the model says the burst is over, with a hard cycle bound.
  task automatic finishBurst();
    int guard;
    guard = 0;
    while (mActive && guard < 20000) begin
      tick();
      guard++;
    end
    if (mActive) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL burstTimeout: burst still active after %0d cycles, required end", guard);
      mActive = 1'b0;
    end
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear at once.
  task automatic midReset();
    rst_n   = 1'b0;
    inReset = 1'b1;
    #1;
    checkOutput("asyncResetMidBurst", {27'b0, sclkO, busyO, sampleO, shiftO, doneO}, 32'h0);
    expQ.delete();
    mActive = 1'b0;
    mPrev   = '0;
    @(negedge clk_in);
    #1;
    @(negedge clk_in);
    #1;
    rst_n   = 1'b1;
    inReset = 1'b0;
  endtask

  // Main sequence: directed cases first, then randomized bursts, then the
  // maximum-divisor, maximum-length burst.
  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk_in);
    #1;
    checkOutput("resetState", {27'b0, sclkO, busyO, sampleO, shiftO, doneO}, 32'h0);
    rst_n   = 1'b1;
    inReset = 1'b0;
    mPrev   = '0;

    $display("[TB] idle cpol tracking");
    runCycles(3, 1'b0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    runCycles(2, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    runCycles(2, 1'b0);

    $display("[TB] directed bursts");
    applyStimulus(1, 0, 1, 0, 0, 8);
    finishBurst();
    runCycles(2, 1'b0);
    applyStimulus(1, 0, 1, 1, 1, 8);
    finishBurst();
    runCycles(2, 1'b0);
    applyStimulus(1, 0, 0, 0, 0, 1);
    finishBurst();
    runCycles(2, 1'b0);

    $display("[TB] abort after fifth edge, then a full burst");
    applyStimulus(1, 0, 3, 0, 0, 4);
    runCycles(20, 1'b1);
    applyStimulus(0, 1, 3, 0, 0, 4);
    finishBurst();
    runCycles(3, 1'b0);
    applyStimulus(1, 0, 3, 0, 0, 4);
    finishBurst();
    runCycles(2, 1'b0);

    $display("[TB] ignored starts");
    applyStimulus(1, 0, 1, 1, 0, 0);
    runCycles(2, 1'b0);
    applyStimulus(1, 0, 1, 0, 0, 40);
    runCycles(2, 1'b0);
    applyStimulus(1, 1, 1, 0, 0, 4);
    runCycles(2, 1'b0);
    applyStimulus(1, 0, 2, 1, 1, 5);
    runCycles(5, 1'b1);
    applyStimulus(1, 0, 0, 0, 0, 3);
    finishBurst();
    runCycles(2, 1'b0);

    $display("[TB] reset mid-burst");
    applyStimulus(1, 0, 2, 1, 1, 6);
    runCycles(17, 1'b1);
    midReset();
    runCycles(3, 1'b0);
    applyStimulus(1, 0, 1, 0, 0, 3);
    finishBurst();
    runCycles(2, 1'b0);

    $display("[TB] randomized bursts");
    for (int k = 0; k < 24; k++) begin
      int dv;
      int nb;
      int cp;
      int ch;
      dv = $urandom_range(0, 6);
      nb = $urandom_range(1, MAX_BITS);
      cp = $urandom_range(0, 1);
      ch = $urandom_range(0, 1);
      applyStimulus(1, 0, dv, cp[0], ch[0], nb);
      if ($urandom_range(0, 3) == 0) begin
        runCycles($urandom_range(0, (2 * nb + 2) * (dv + 1)), 1'b1);
        applyStimulus(0, 1, dv, cp[0], ch[0], nb);
      end
      if ($urandom_range(0, 2) == 0) begin
        runCycles($urandom_range(0, 4), 1'b1);
        applyStimulus(1, 0, $urandom_range(0, 6), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom_range(1, MAX_BITS));
      end
      finishBurst();
      runCycles($urandom_range(0, 3), 1'b1);
    end

    $display("[TB] maximum divisor, maximum bits");
    applyStimulus(1, 0, 255, 0, 0, 32);
    finishBurst();

    runCycles(4, 1'b0);
    checkOutput("queueDrained", expQ.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
